fifo_rd_ctrl: RTL

Read-side controller for the synchronous FIFO, and the counterpart of the write-address/flag logic. It owns the extended read pointer and issues reads to the 1-cycle-latency FIFO memory. It lands returned words in a 2-entry output skid buffer and presents them on a valid/ready master stream at full throughput. The write pointer is consumed for emptiness; the read pointer is fed back to the flag comparator.

---
 rtl/fifo_rd_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read pointer, 1-cycle memory read issue, 2-entry output skid buffer (FIFO_RD_LEVEL_EN adds o_level).
// Latency: first word valid 2 cycles after the FIFO goes non-empty; 1 word/cycle sustained with ready high.
// Backpressure: reads issue only while buffered + in-flight words stay below 2; head held stable while !i_ready_m.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

module fifo_rd_ctrl #(
   parameter int FIFO_DEPTH = `FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   i_wr_addr,
   output logic [ADDR_WIDTH:0]   o_rd_addr,
   output logic                  o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0] o_mem_raddr,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic [DATA_WIDTH-1:0] o_data_m,
   output logic                  o_valid_m,
   input  logic                  i_ready_m
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [ADDR_WIDTH+1:0] o_level
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

   buf_state_e            state_q, state_d;
   logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] second_q, second_d;

   logic [ADDR_WIDTH:0]   avail;
   logic [1:0]            buf_cnt;
   logic [2:0]            committed;
   logic                  pop;
   logic                  land;
   logic                  issue;

   // Credit: words already held or returning, minus the one leaving this cycle.
   always_comb begin
      avail     = i_wr_addr - rd_addr_q;
      land      = inflight_q;
      pop       = (state_q != ST_EMPTY) && i_ready_m;
      case (state_q)
         ST_ONE:  buf_cnt = 2'd1;
         ST_TWO:  buf_cnt = 2'd2;
         default: buf_cnt = 2'd0;
      endcase
      committed = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
      issue     = (avail != '0) && (committed < 3'd2);
      rd_addr_d = issue ? (rd_addr_q + {{ADDR_WIDTH{1'b0}}, 1'b1}) : rd_addr_q;
      inflight_d = issue;
   end

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      second_d = second_q;
      case (state_q)
         ST_EMPTY: begin
            if (land) begin
               state_d = ST_ONE;
               head_d  = i_mem_rdata;
            end
         end
         ST_ONE: begin
            if (land && pop) begin
               head_d = i_mem_rdata;
            end else if (land) begin
               state_d  = ST_TWO;
               second_d = i_mem_rdata;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (pop) begin
               head_d = second_q;
               if (land) begin
                  second_d = i_mem_rdata;
               end else begin
                  state_d = ST_ONE;
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         rd_addr_q  <= '0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         second_q   <= '0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         second_q   <= second_d;
      end
   end

   assign o_rd_addr   = rd_addr_q;
   assign o_mem_rd_en = issue;
   assign o_mem_raddr = rd_addr_q[ADDR_WIDTH-1:0];
   assign o_data_m    = head_q;
   assign o_valid_m   = (state_q != ST_EMPTY);

`ifdef FIFO_RD_LEVEL_EN
   logic [ADDR_WIDTH+1:0] level_q, level_d;
   logic [ADDR_WIDTH:0]   avail_d;
   logic [1:0]            buf_cnt_d;

   // Words still in memory, in flight, or buffered once this edge's updates land.
   always_comb begin
      avail_d = i_wr_addr - rd_addr_d;
      case (state_d)
         ST_ONE:  buf_cnt_d = 2'd1;
         ST_TWO:  buf_cnt_d = 2'd2;
         default: buf_cnt_d = 2'd0;
      endcase
      level_d = {1'b0, avail_d}
              + {{(ADDR_WIDTH+1){1'b0}}, inflight_d}
              + {{ADDR_WIDTH{1'b0}}, buf_cnt_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign o_level = level_q;
`endif

endmodule
